// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode map, immediate formats and the ID/EX payload.
package rv32i_pkg;

   localparam int unsigned REG_W   = 32;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned NREGS   = 32;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned F7_W    = 7;

   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_R,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   typedef struct packed {
      logic               valid;
      logic [REG_W-1:0]   pc;
      logic [F3_W-1:0]    func3;
      logic [F7_W-1:0]    func7;
      logic [REG_W-1:0]   imm;
      logic               is_r;
      logic               is_i;
      logic               is_load;
      logic               is_store;
      logic               is_branch;
      logic               is_jal;
      logic               is_jalr;
      logic               is_lui;
      logic               is_auipc;
      logic [REG_W-1:0]   rs1;
      logic [REG_W-1:0]   rs2;
      logic [RADDR_W-1:0] rs1_addr;
      logic [RADDR_W-1:0] rs2_addr;
      logic [RADDR_W-1:0] rd;
      logic               reg_write;
      logic               illegal;
   } id_ex_t;

   // Sign-extended immediate for the given format; bit 31 is always the sign.
   function automatic logic [REG_W-1:0] imm_gen(input logic [REG_W-1:0] instr,
                                                 input imm_fmt_e fmt);
      logic [REG_W-1:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: one clocked write port, two write-through read ports, x0 reads 0.
module regfile
   import rv32i_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [RADDR_W-1:0] wa,
   input  logic [REG_W-1:0]   wd,
   input  logic [RADDR_W-1:0] ra1,
   input  logic [RADDR_W-1:0] ra2,
   output logic [REG_W-1:0]   rd1_c,
   output logic [REG_W-1:0]   rd2_c
);

   logic [REG_W-1:0] mem [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   // Same-cycle writeback is forwarded so decode never latches a stale operand.
   always_comb begin
      rd1_c = '0;
      rd2_c = '0;
      if (ra1 != '0) rd1_c = (we && (wa == ra1)) ? wd : mem[ra1];
      if (ra2 != '0) rd2_c = (we && (wa == ra2)) ? wd : mem[ra2];
   end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, immediate generation, register file read
// and the ID/EX pipeline register with stall/flush control.
module id_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_instr,
   input  logic               stall,
   input  logic               flush,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [F3_W-1:0]    ex_func3,
   output logic [F7_W-1:0]    ex_func7,
   output logic [XLEN-1:0]    ex_imm,
   output logic               ex_is_Rtype,
   output logic               ex_is_Itype,
   output logic               ex_is_load,
   output logic               ex_is_store,
   output logic               ex_is_branch,
   output logic               ex_is_jal,
   output logic               ex_is_jalr,
   output logic               ex_is_lui,
   output logic               ex_is_auipc,
   output logic [XLEN-1:0]    ex_rs1,
   output logic [XLEN-1:0]    ex_rs2,
   output logic [RADDR_W-1:0] ex_rs1_addr,
   output logic [RADDR_W-1:0] ex_rs2_addr,
   output logic [RADDR_W-1:0] ex_rd,
   output logic               ex_reg_write,
   output logic               ex_illegal
);

   logic [REG_W-1:0] rs1_c;
   logic [REG_W-1:0] rs2_c;
   logic [OPC_W-1:0] opcode;
   logic [F3_W-1:0]  f3;
   imm_fmt_e         fmt;
   logic             writes_rd;
   id_ex_t           dec;
   id_ex_t           ex_d;
   id_ex_t           ex_q;

   assign opcode = id_instr[6:0];
   assign f3     = id_instr[14:12];

   regfile u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_we),
      .wa    (wb_rd),
      .wd    (wb_data),
      .ra1   (id_instr[19:15]),
      .ra2   (id_instr[24:20]),
      .rd1_c (rs1_c),
      .rd2_c (rs2_c)
   );

   // Instruction decode into the ID/EX payload.
   always_comb begin
      dec       = '0;
      fmt       = IMM_R;
      writes_rd = 1'b0;

      dec.valid    = 1'b1;
      dec.pc       = id_pc;
      dec.func3    = f3;
      dec.rs1_addr = id_instr[19:15];
      dec.rs2_addr = id_instr[24:20];
      dec.rd       = id_instr[11:7];
      dec.rs1      = rs1_c;
      dec.rs2      = rs2_c;

      case (opcode)
         OP_R: begin
            dec.is_r  = 1'b1;
            dec.func7 = id_instr[31:25];
            writes_rd = 1'b1;
         end
         OP_IMM: begin
            dec.is_i  = 1'b1;
            fmt       = IMM_I;
            writes_rd = 1'b1;
            if ((f3 == 3'b001) || (f3 == 3'b101)) dec.func7 = id_instr[31:25];
         end
         OP_LOAD: begin
            dec.is_load = 1'b1;
            fmt         = IMM_I;
            writes_rd   = 1'b1;
         end
         OP_STORE: begin
            dec.is_store = 1'b1;
            fmt          = IMM_S;
         end
         OP_BRANCH: begin
            dec.is_branch = 1'b1;
            fmt           = IMM_B;
         end
         OP_JAL: begin
            dec.is_jal = 1'b1;
            dec.func3  = '0;
            fmt        = IMM_J;
            writes_rd  = 1'b1;
         end
         OP_JALR: begin
            dec.is_jalr = 1'b1;
            fmt         = IMM_I;
            writes_rd   = 1'b1;
         end
         OP_LUI: begin
            dec.is_lui = 1'b1;
            dec.func3  = '0;
            fmt        = IMM_U;
            writes_rd  = 1'b1;
         end
         OP_AUIPC: begin
            dec.is_auipc = 1'b1;
            dec.func3    = '0;
            fmt          = IMM_U;
            writes_rd    = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
            dec.func3   = '0;
         end
      endcase

      dec.imm       = imm_gen(id_instr, fmt);
      dec.reg_write = writes_rd && (dec.rd != '0);
   end

   // ID/EX next value: flush beats stall; a stalled operand still tracks writeback.
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d = '0;
      end else if (stall) begin
         if (wb_we && (wb_rd != '0) && (wb_rd == ex_q.rs1_addr)) ex_d.rs1 = wb_data;
         if (wb_we && (wb_rd != '0) && (wb_rd == ex_q.rs2_addr)) ex_d.rs2 = wb_data;
      end else if (id_valid) begin
         ex_d = dec;
      end else begin
         ex_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q    <= '0;
         ex_q.pc <= RESET_PC;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_pc        = ex_q.pc;
   assign ex_func3     = ex_q.func3;
   assign ex_func7     = ex_q.func7;
   assign ex_imm       = ex_q.imm;
   assign ex_is_Rtype  = ex_q.is_r;
   assign ex_is_Itype  = ex_q.is_i;
   assign ex_is_load   = ex_q.is_load;
   assign ex_is_store  = ex_q.is_store;
   assign ex_is_branch = ex_q.is_branch;
   assign ex_is_jal    = ex_q.is_jal;
   assign ex_is_jalr   = ex_q.is_jalr;
   assign ex_is_lui    = ex_q.is_lui;
   assign ex_is_auipc  = ex_q.is_auipc;
   assign ex_rs1       = ex_q.rs1;
   assign ex_rs2       = ex_q.rs2;
   assign ex_rs1_addr  = ex_q.rs1_addr;
   assign ex_rs2_addr  = ex_q.rs2_addr;
   assign ex_rd        = ex_q.rd;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_illegal   = ex_q.illegal;

endmodule
